// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard/sequencing controller for the five-stage core.
// Drives the enable, hold and active-low clear controls of the IF/ID, ID/EX, EX/DM
// and DM/WB pipeline registers and the PC write enable. It resolves load-use hazards,
// EX-stage redirects, data-memory wait freezes and the halt drain/resume sequence,
// and keeps saturating stall/flush counters for debug.
//
// Ports:
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   id_rs_i/id_rt_i          source register fields of the ID instruction
//   id_use_rs_i/id_use_rt_i  ID instruction actually reads rs/rt
//   ex_regfile_w_en_i        EX instruction writes the register file
//   ex_regfile_req_w_i       EX destination register
//   ex_is_load_i             EX writeback data comes from data memory
//   ex_redirect_i            EX-stage mispredict, PC mux already on the correct target
//   ex_halt_i / wb_halt_i    halt instruction in EX / registered into DM/WB
//   dm_busy_i                data memory cannot complete this cycle
//   resume_i                 single-cycle restart request while halted
//   pc_en_o, *_en_o          register write enables
//   if_id_stall_o            IF/ID hold
//   *_clr_o                  register clears, active-low
//   halted_o                 core is halted (registered)
//   stall_cnt_o/flush_cnt_o  saturating load-use stall / redirect counters

module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  input  logic             ex_regfile_w_en_i,
  input  logic [4:0]       ex_regfile_req_w_i,
  input  logic             ex_is_load_i,
  input  logic             ex_redirect_i,
  input  logic             ex_halt_i,
  input  logic             wb_halt_i,
  input  logic             dm_busy_i,
  input  logic             resume_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             if_id_stall_o,
  output logic             if_id_clr_o,
  output logic             id_ex_en_o,
  output logic             id_ex_clr_o,
  output logic             ex_dm_en_o,
  output logic             ex_dm_clr_o,
  output logic             dm_wb_en_o,
  output logic             dm_wb_clr_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e           state_q, state_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu;
  logic stall_inc, flush_inc;
  logic pc_en, if_id_en, if_id_stall, if_id_clr, id_ex_en, id_ex_clr;
  logic ex_dm_en, ex_dm_clr, dm_wb_en, dm_wb_clr;

  // $0 is never a real producer, so a load targeting it cannot create a hazard.
  assign lu = ex_is_load_i && ex_regfile_w_en_i && (ex_regfile_req_w_i != 5'd0) &&
              ((id_use_rs_i && (id_rs_i == ex_regfile_req_w_i)) ||
               (id_use_rt_i && (id_rt_i == ex_regfile_req_w_i)));

  always_comb begin
    // Safe default: everything frozen, no clears.
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_stall = 1'b0;
    if_id_clr   = 1'b1;
    id_ex_en    = 1'b0;
    id_ex_clr   = 1'b1;
    ex_dm_en    = 1'b0;
    ex_dm_clr   = 1'b1;
    dm_wb_en    = 1'b0;
    dm_wb_clr   = 1'b1;
    state_d     = state_q;
    halted_d    = halted_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    unique case (state_q)
      StRun: begin
        if (!dm_busy_i) begin
          pc_en    = 1'b1;
          if_id_en = 1'b1;
          id_ex_en = 1'b1;
          ex_dm_en = 1'b1;
          dm_wb_en = 1'b1;
          if (ex_halt_i) begin
            // Stop fetching and squash younger work; let the halt flow to WB.
            pc_en     = 1'b0;
            if_id_clr = 1'b0;
            id_ex_clr = 1'b0;
            state_d   = StDrain;
          end else if (ex_redirect_i) begin
            // Redirect wins over load-use: the dependent instruction is squashed anyway.
            if_id_clr = 1'b0;
            id_ex_clr = 1'b0;
            flush_inc = 1'b1;
          end else if (lu) begin
            pc_en       = 1'b0;
            if_id_stall = 1'b1;
            id_ex_clr   = 1'b0;
            stall_inc   = 1'b1;
          end
        end
      end
      StDrain: begin
        if (!dm_busy_i) begin
          if_id_clr = 1'b0;
          id_ex_clr = 1'b0;
          ex_dm_en  = 1'b1;
          dm_wb_en  = 1'b1;
        end
        if (wb_halt_i) begin
          state_d  = StHalted;
          halted_d = 1'b1;
        end
      end
      StHalted: begin
        if (resume_i) begin
          // Restart from a clean pipeline.
          if_id_clr = 1'b0;
          id_ex_clr = 1'b0;
          ex_dm_clr = 1'b0;
          dm_wb_clr = 1'b0;
          state_d   = StRun;
          halted_d  = 1'b0;
        end
      end
      default: state_d = StRun;
    endcase

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Outputs are forced to the frozen/no-clear pattern while reset is held.
  assign pc_en_o       = rst_n & pc_en;
  assign if_id_en_o    = rst_n & if_id_en;
  assign if_id_stall_o = rst_n & if_id_stall;
  assign if_id_clr_o   = ~rst_n | if_id_clr;
  assign id_ex_en_o    = rst_n & id_ex_en;
  assign id_ex_clr_o   = ~rst_n | id_ex_clr;
  assign ex_dm_en_o    = rst_n & ex_dm_en;
  assign ex_dm_clr_o   = ~rst_n | ex_dm_clr;
  assign dm_wb_en_o    = rst_n & dm_wb_en;
  assign dm_wb_clr_o   = ~rst_n | dm_wb_clr;
  assign halted_o      = halted_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a table of single-cycle RUN vectors,
// hand-written multi-cycle sequences (load-use, redirect, dm_busy, halt/resume,
// reset mid-drain, counter saturation) and a randomized run against a reference model.

module tb_pipeline_hazard_ctrl;

  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  // Output pattern {pc, ifid_en, ifid_stall, ifid_clr, idex_en, idex_clr,
  //                 exdm_en, exdm_clr, dmwb_en, dmwb_clr}
  localparam logic [9:0] O_RUN    = 10'b1_1_0_1_1_1_1_1_1_1;
  localparam logic [9:0] O_FREEZE = 10'b0_0_0_1_0_1_0_1_0_1;
  localparam logic [9:0] O_HALT   = 10'b0_1_0_0_1_0_1_1_1_1;
  localparam logic [9:0] O_REDIR  = 10'b1_1_0_0_1_0_1_1_1_1;
  localparam logic [9:0] O_LU     = 10'b0_1_1_1_1_0_1_1_1_1;
  localparam logic [9:0] O_DRAIN  = 10'b0_0_0_0_0_0_1_1_1_1;
  localparam logic [9:0] O_RESUME = 10'b0_0_0_0_0_0_0_0_0_0;

  typedef struct {
    logic [4:0] rs, rt, req;
    logic       urs, urt, wen, load, redir, halt, wbh, busy, res;
  } in_t;

  typedef struct {
    string      name;
    in_t        i;
    logic [9:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs, id_rt, req_w;
  logic id_use_rs, id_use_rt, w_en, is_load, redirect, halt, wb_halt, dm_busy, resume;
  logic pc_en, if_id_en, if_id_stall, if_id_clr, id_ex_en, id_ex_clr;
  logic ex_dm_en, ex_dm_clr, dm_wb_en, dm_wb_clr, halted;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [9:0] outs;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: 0 = running, 1 = draining, 2 = halted.
  int m_mode, m_halted, m_stall, m_flush;

  always #5 clk = ~clk;

  assign outs = {pc_en, if_id_en, if_id_stall, if_id_clr, id_ex_en, id_ex_clr,
                 ex_dm_en, ex_dm_clr, dm_wb_en, dm_wb_clr};

  pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .id_rs_i            (id_rs),
    .id_rt_i            (id_rt),
    .id_use_rs_i        (id_use_rs),
    .id_use_rt_i        (id_use_rt),
    .ex_regfile_w_en_i  (w_en),
    .ex_regfile_req_w_i (req_w),
    .ex_is_load_i       (is_load),
    .ex_redirect_i      (redirect),
    .ex_halt_i          (halt),
    .wb_halt_i          (wb_halt),
    .dm_busy_i          (dm_busy),
    .resume_i           (resume),
    .pc_en_o            (pc_en),
    .if_id_en_o         (if_id_en),
    .if_id_stall_o      (if_id_stall),
    .if_id_clr_o        (if_id_clr),
    .id_ex_en_o         (id_ex_en),
    .id_ex_clr_o        (id_ex_clr),
    .ex_dm_en_o         (ex_dm_en),
    .ex_dm_clr_o        (ex_dm_clr),
    .dm_wb_en_o         (dm_wb_en),
    .dm_wb_clr_o        (dm_wb_clr),
    .halted_o           (halted),
    .stall_cnt_o        (stall_cnt),
    .flush_cnt_o        (flush_cnt)
  );

  function automatic in_t mk(int load, int wen, int req, int rs, int urs, int rt, int urt,
                             int redir, int hlt, int wbh, int busy, int res);
    in_t v;
    v.load = 1'(load); v.wen = 1'(wen); v.req = 5'(req);
    v.rs = 5'(rs); v.urs = 1'(urs); v.rt = 5'(rt); v.urt = 1'(urt);
    v.redir = 1'(redir); v.halt = 1'(hlt); v.wbh = 1'(wbh); v.busy = 1'(busy);
    v.res = 1'(res);
    return v;
  endfunction

  function automatic bit m_lu(in_t v);
    return v.load && v.wen && (v.req != 0) &&
           ((v.urs && v.rs == v.req) || (v.urt && v.rt == v.req));
  endfunction

  function automatic logic [9:0] m_out(in_t v);
    case (m_mode)
      0: begin
        if (v.busy)       return O_FREEZE;
        if (v.halt)       return O_HALT;
        if (v.redir)      return O_REDIR;
        if (m_lu(v))      return O_LU;
        return O_RUN;
      end
      1:       return v.busy ? O_FREEZE : O_DRAIN;
      default: return v.res ? O_RESUME : O_FREEZE;
    endcase
  endfunction

  function automatic void m_next(in_t v);
    case (m_mode)
      0: if (!v.busy) begin
        if (v.halt)         m_mode = 1;
        else if (v.redir)   m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        else if (m_lu(v))   m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      end
      1: if (v.wbh) begin m_mode = 2; m_halted = 1; end
      default: if (v.res) begin m_mode = 0; m_halted = 0; end
    endcase
  endfunction

  function automatic void m_reset();
    m_mode = 0; m_halted = 0; m_stall = 0; m_flush = 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input in_t v);
    id_rs = v.rs; id_rt = v.rt; req_w = v.req; id_use_rs = v.urs; id_use_rt = v.urt;
    w_en = v.wen; is_load = v.load; redirect = v.redir; halt = v.halt;
    wb_halt = v.wbh; dm_busy = v.busy; resume = v.res;
  endtask

  // Called just after a rising edge: drive, check outputs mid-cycle, advance one clock.
  task automatic step(input in_t v, input string name, input logic [9:0] exp);
    drive(v);
    #3;
    chk(name, 32'(outs), 32'(exp));
    m_next(v);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #3;
    chk("rst_outs", 32'(outs), 32'(O_FREEZE));
    chk("rst_halted", 32'(halted), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_flush", 32'(flush_cnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset();
  endtask

  in_t  idle, lu3, bubble, redlu, busyred, red, hlt, wbh, noisy, res;
  vec_t tbl[12];
  in_t  rv;

  initial begin
    idle    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu3     = mk(1, 1, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    bubble  = mk(0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    redlu   = mk(1, 1, 3, 3, 1, 0, 0, 1, 0, 0, 0, 0);
    busyred = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    red     = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    hlt     = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    wbh     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    noisy   = mk(1, 1, 3, 3, 1, 0, 0, 1, 0, 0, 0, 0);
    res     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    tbl[0]  = '{"none",         idle,                                       O_RUN};
    tbl[1]  = '{"lu_rs",        lu3,                                        O_LU};
    tbl[2]  = '{"req_zero",     mk(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0),     O_RUN};
    tbl[3]  = '{"no_use_rs",    mk(1, 1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0),     O_RUN};
    tbl[4]  = '{"lu_rt",        mk(1, 1, 7, 1, 1, 7, 1, 0, 0, 0, 0, 0),     O_LU};
    tbl[5]  = '{"no_wen",       mk(1, 0, 3, 3, 1, 3, 1, 0, 0, 0, 0, 0),     O_RUN};
    tbl[6]  = '{"not_load",     mk(0, 1, 3, 3, 1, 3, 1, 0, 0, 0, 0, 0),     O_RUN};
    tbl[7]  = '{"redir_lu",     redlu,                                      O_REDIR};
    tbl[8]  = '{"busy_redir",   busyred,                                    O_FREEZE};
    tbl[9]  = '{"busy_lu",      mk(1, 1, 3, 3, 1, 0, 0, 0, 0, 0, 1, 0),     O_FREEZE};
    tbl[10] = '{"rt_unused",    mk(1, 1, 9, 2, 1, 9, 0, 0, 0, 0, 0, 0),     O_RUN};
    tbl[11] = '{"resume_run",   res,                                        O_RUN};

    drive(idle);
    m_reset();
    @(posedge clk);
    #1;
    do_reset();

    foreach (tbl[k]) step(tbl[k].i, tbl[k].name, tbl[k].exp);

    // Single load-use stall, then the bubble removes the hazard.
    do_reset();
    step(lu3, "lu_stall", O_LU);
    chk("lu_stall_cnt", 32'(stall_cnt), 1);
    step(bubble, "lu_after", O_RUN);
    chk("lu_stall_cnt_hold", 32'(stall_cnt), 1);

    // Redirect coincident with load-use.
    do_reset();
    step(redlu, "redlu", O_REDIR);
    chk("redlu_flush", 32'(flush_cnt), 1);
    chk("redlu_stall", 32'(stall_cnt), 0);

    // dm_busy holds a pending redirect for three cycles.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(busyred, "busy_freeze", O_FREEZE);
      chk("busy_flush_hold", 32'(flush_cnt), 0);
    end
    step(red, "busy_release", O_REDIR);
    chk("busy_flush", 32'(flush_cnt), 1);

    // Halt, drain, halted, resume.
    do_reset();
    step(hlt, "halt_ex", O_HALT);
    chk("halt_not_yet", 32'(halted), 0);
    step(idle, "drain1", O_DRAIN);
    step(wbh, "drain2", O_DRAIN);
    chk("halted_set", 32'(halted), 1);
    step(noisy, "halted_ignore", O_FREEZE);
    chk("halted_flush_hold", 32'(flush_cnt), 0);
    step(res, "resume", O_RESUME);
    chk("halted_clr", 32'(halted), 0);
    step(idle, "after_resume", O_RUN);

    // Asynchronous reset in the middle of a drain.
    do_reset();
    for (int k = 0; k < 5; k++) step(lu3, "pre_stall", O_LU);
    chk("pre_stall_cnt", 32'(stall_cnt), 5);
    step(hlt, "pre_halt", O_HALT);
    drive(idle);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", 32'(outs), 32'(O_FREEZE));
    chk("midrst_stall", 32'(stall_cnt), 0);
    chk("midrst_halted", 32'(halted), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset();
    step(idle, "midrst_run", O_RUN);

    // Stall counter saturation.
    do_reset();
    for (int k = 0; k < CMAX + 3; k++) step(lu3, "sat_stall", O_LU);
    chk("sat_stall_cnt", 32'(stall_cnt), CMAX);

    // Randomized run against the model.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      rv.load  = 1'($urandom_range(0, 1));
      rv.wen   = ($urandom_range(0, 3) != 0);
      rv.req   = 5'($urandom_range(0, 3));
      rv.rs    = 5'($urandom_range(0, 3));
      rv.rt    = 5'($urandom_range(0, 3));
      rv.urs   = 1'($urandom_range(0, 1));
      rv.urt   = 1'($urandom_range(0, 1));
      rv.redir = ($urandom_range(0, 4) == 0);
      rv.halt  = ($urandom_range(0, 19) == 0);
      rv.wbh   = ($urandom_range(0, 4) == 0);
      rv.busy  = ($urandom_range(0, 4) == 0);
      rv.res   = ($urandom_range(0, 4) == 0);
      drive(rv);
      #3;
      chk("rnd_outs", 32'(outs), 32'(m_out(rv)));
      chk("rnd_halted", 32'(halted), 32'(m_halted));
      chk("rnd_stall", 32'(stall_cnt), 32'(m_stall));
      chk("rnd_flush", 32'(flush_cnt), 32'(m_flush));
      m_next(rv);
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
